instruction_fetch_stage: RTL and testbench
==========================================

# instruction_fetch_stage

Fetch stage of the five-stage pipeline. Owns the program-counter register, drives the address into the combinational instruction memory, and captures the returned word into the IF/ID pipeline register for decode. Handles hazard stalls, branch/jump redirects from decode, and full pipeline flushes.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- FLUSH_PC, 32'h0000_0000: PC value loaded on flush (exception entry).

- clock  input  1  sole clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- programCounter  output  32  current fetch PC, to instruction memory.
- instructionData  input  32  word returned combinationally by instruction memory for programCounter.
- stall  input  1  hazard unit: hold PC and IF/ID this cycle.
- redirect  input  1  decode: taken branch/jump this cycle.
- redirectTarget  input  32  target PC qualified by redirect.
- flush  input  1  squash IF/ID and restart at FLUSH_PC.
- decodeValid  output  1  IF/ID holds a real instruction.
- decodeInstruction  output  32  IF/ID instruction word.
- decodePc  output  32  PC of decodeInstruction.
- decodeNextPc  output  32  decodePc + 4.
- decodeFault  output  1  decodePc[1:0] != 0; instruction still delivered.

## Operation
- Reset (reset low, asynchronous): programCounter = RESET_PC; decodeValid = 0; decodeInstruction = 0; decodePc = 0; decodeNextPc = 0; decodeFault = 0. Release is synchronous to the next rising edge; the first fetch occurs in the first cycle after release.
- Per-cycle priority, evaluated at each rising edge: flush > stall > redirect > sequential.
- flush: programCounter <= FLUSH_PC; decodeValid <= 0; other IF/ID fields <= 0. Overrides stall and redirect.
- stall (no flush): programCounter and all IF/ID outputs hold. redirect is ignored; decode holds the branch and reasserts redirect once stall drops.
- redirect (no flush, no stall): programCounter <= redirectTarget. IF/ID treatment of the word fetched this cycle depends on FETCH_BRANCH_DELAY_SLOT_EN (see Configuration).
- Sequential: programCounter <= programCounter + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0). IF/ID <= {valid = 1, instruction = instructionData, pc = programCounter, nextPc = programCounter + 4, fault = |programCounter[1:0]}.
- Misaligned targets are not corrected; the PC advances by 4 from the misaligned value and every such fetch raises decodeFault. Memory ignores bits [1:0].
- decodeNextPc always equals decodePc + 4 (wrapping) when decodeValid = 1.

## Timing
- Fetch latency: one cycle. The word at PC P appears on decodeInstruction on the edge after programCounter = P, provided no stall, flush, or squash occurs.
- programCounter is a pure register output; no combinational path from any input to programCounter.
- IF/ID outputs are registered; no combinational input-to-output path.
- redirect to first target instruction valid at decode: two edges. The target is fetched in the cycle after the redirect edge.
- flush to first FLUSH_PC instruction valid at decode: two edges. decodeValid is 0 for exactly one cycle when no stall follows.
- Reset asserted mid-operation: all state returns to reset values immediately, regardless of clock.

## Configuration
- FETCH_BRANCH_DELAY_SLOT_EN defined: MIPS delay-slot semantics. On a redirect edge the word fetched that cycle (branch PC + 4) is latched into IF/ID as valid, exactly as in the sequential case.
- Undefined: on a redirect edge IF/ID is squashed (decodeValid <= 0, fields <= 0). Exactly one bubble per taken branch.
- flush behaviour is identical in both builds.

## Test plan
- Reset release with RESET_PC = 0, memory word i = 0x1000_0000 + i, no control inputs -> programCounter 0, 4, 8, ...; decodeValid rises after the first edge, then decodeInstruction 0x1000_0000, 0x1000_0001, ... with decodePc 0, 4, ...
- stall held 3 cycles while programCounter = 0x10 -> programCounter stays 0x10 and IF/ID stays at pc 0xC for 3 cycles; the sequence then resumes with no skipped or duplicated instruction.
- redirect to 0x40 while programCounter = 0x14 -> next programCounter = 0x40. Without macro, decodeValid = 0 for one cycle, then the 0x40 word. With macro, the 0x14 word is delivered valid, then the 0x40 word.
- redirect and stall both high, then stall low with redirect held -> first edge holds everything; second edge redirects to the target.
- flush together with stall and redirect, FLUSH_PC = 0x180 -> programCounter = 0x180, decodeValid = 0; the 0x180 word appears at decode on the following edge.
- redirect to 0x22, then 0xFFFF_FFFC sequential -> decodeFault = 1 with decodePc 0x22 and then 0x26; the 0xFFFF_FFFC fetch is followed by programCounter = 0, and decodeNextPc for 0xFFFF_FFFC = 0; reset asserted mid-sequence clears all outputs asynchronously.

Source files
------------

// File: rtl/instruction_fetch_stage.sv
// rtl/instruction_fetch_stage.sv - PC register and IF/ID pipeline register for the fetch stage.
// Optional macro FETCH_BRANCH_DELAY_SLOT_EN keeps the word fetched on a redirect edge (delay slot).
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] FLUSH_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] programCounter,
  input  logic [31:0] instructionData,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirectTarget,
  input  logic        flush,
  output logic        decodeValid,
  output logic [31:0] decodeInstruction,
  output logic [31:0] decodePc,
  output logic [31:0] decodeNextPc,
  output logic        decodeFault
);

  logic [31:0] pc_q, pc_d, pc_plus4;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] dpc_q, dpc_d;
  logic [31:0] dnpc_q, dnpc_d;
  logic        fault_q, fault_d;

  assign pc_plus4 = pc_q + 32'd4;

  // Priority: flush > stall > redirect > sequential.
  always_comb begin
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    dpc_d   = dpc_q;
    dnpc_d  = dnpc_q;
    fault_d = fault_q;
    if (flush) begin
      pc_d    = FLUSH_PC;
      valid_d = 1'b0;
      instr_d = 32'd0;
      dpc_d   = 32'd0;
      dnpc_d  = 32'd0;
      fault_d = 1'b0;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (redirect) begin
      pc_d = redirectTarget;
`ifdef FETCH_BRANCH_DELAY_SLOT_EN
      valid_d = 1'b1;
      instr_d = instructionData;
      dpc_d   = pc_q;
      dnpc_d  = pc_plus4;
      fault_d = |pc_q[1:0];
`else
      valid_d = 1'b0;
      instr_d = 32'd0;
      dpc_d   = 32'd0;
      dnpc_d  = 32'd0;
      fault_d = 1'b0;
`endif
    end else begin
      pc_d    = pc_plus4;
      valid_d = 1'b1;
      instr_d = instructionData;
      dpc_d   = pc_q;
      dnpc_d  = pc_plus4;
      fault_d = |pc_q[1:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= 32'd0;
      dpc_q   <= 32'd0;
      dnpc_q  <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      dpc_q   <= dpc_d;
      dnpc_q  <= dnpc_d;
      fault_q <= fault_d;
    end
  end

  assign programCounter    = pc_q;
  assign decodeValid       = valid_q;
  assign decodeInstruction = instr_q;
  assign decodePc          = dpc_q;
  assign decodeNextPc      = dnpc_q;
  assign decodeFault       = fault_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb/tb_instruction_fetch_stage.sv - directed self-checking bench for instruction_fetch_stage.
module tb_instruction_fetch_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] programCounter;
  logic [31:0] instructionData;
  logic        stall, redirect, flush;
  logic [31:0] redirectTarget;
  logic        decodeValid;
  logic [31:0] decodeInstruction, decodePc, decodeNextPc;
  logic        decodeFault;

  int tests = 0;
  int fails = 0;

  // Decode bundle: {valid, instruction, pc, nextPc, fault} = 98 bits.
  logic [97:0] dec;
  logic [97:0] exp_dec;
  assign dec = {decodeValid, decodeInstruction, decodePc, decodeNextPc, decodeFault};

  // Memory word i (address 4*i) holds 0x1000_0000 + i; bits [1:0] ignored.
  assign instructionData = 32'h1000_0000 + {2'b00, programCounter[31:2]};

  always #5 clock = ~clock;

  instruction_fetch_stage #(
    .RESET_PC(32'h0000_0000),
    .FLUSH_PC(32'h0000_0180)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .programCounter   (programCounter),
    .instructionData  (instructionData),
    .stall            (stall),
    .redirect         (redirect),
    .redirectTarget   (redirectTarget),
    .flush            (flush),
    .decodeValid      (decodeValid),
    .decodeInstruction(decodeInstruction),
    .decodePc         (decodePc),
    .decodeNextPc     (decodeNextPc),
    .decodeFault      (decodeFault)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; stall = 0; redirect = 0; flush = 0; redirectTarget = 32'd0;
    tick(); tick();
    tests++;
    if (programCounter !== 32'h0) begin
      fails++; $display("FAIL reset_pc: got %h expected %h", programCounter, 32'h0);
    end
    exp_dec = '0;
    tests++;
    if (dec !== exp_dec) begin
      fails++; $display("FAIL reset_decode: got %h expected %h", dec, exp_dec);
    end
  endtask

  task automatic test_sequential();
    reset = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp_dec = {1'b1, 32'h1000_0000 + 32'(k - 1), 32'(4 * (k - 1)), 32'(4 * k), 1'b0};
      tests++;
      if (programCounter !== 32'(4 * k)) begin
        fails++; $display("FAIL seq_pc[%0d]: got %h expected %h", k, programCounter, 32'(4 * k));
      end
      tests++;
      if (dec !== exp_dec) begin
        fails++; $display("FAIL seq_decode[%0d]: got %h expected %h", k, dec, exp_dec);
      end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    exp_dec = {1'b1, 32'h1000_0003, 32'h0C, 32'h10, 1'b0};
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++;
      if (programCounter !== 32'h10) begin
        fails++; $display("FAIL stall_pc[%0d]: got %h expected %h", k, programCounter, 32'h10);
      end
      tests++;
      if (dec !== exp_dec) begin
        fails++; $display("FAIL stall_decode[%0d]: got %h expected %h", k, dec, exp_dec);
      end
    end
    stall = 1'b0;
    tick();
    exp_dec = {1'b1, 32'h1000_0004, 32'h10, 32'h14, 1'b0};
    tests++;
    if (programCounter !== 32'h14 || dec !== exp_dec) begin
      fails++; $display("FAIL stall_resume: got pc %h dec %h expected pc %h dec %h",
                        programCounter, dec, 32'h14, exp_dec);
    end
  endtask

  task automatic test_redirect();
    redirect = 1'b1; redirectTarget = 32'h40;
    tick();
    redirect = 1'b0;
`ifdef FETCH_BRANCH_DELAY_SLOT_EN
    exp_dec = {1'b1, 32'h1000_0005, 32'h14, 32'h18, 1'b0};
`else
    exp_dec = '0;
`endif
    tests++;
    if (programCounter !== 32'h40 || dec !== exp_dec) begin
      fails++; $display("FAIL redirect_edge: got pc %h dec %h expected pc %h dec %h",
                        programCounter, dec, 32'h40, exp_dec);
    end
    tick();
    exp_dec = {1'b1, 32'h1000_0010, 32'h40, 32'h44, 1'b0};
    tests++;
    if (programCounter !== 32'h44 || dec !== exp_dec) begin
      fails++; $display("FAIL redirect_target: got pc %h dec %h expected pc %h dec %h",
                        programCounter, dec, 32'h44, exp_dec);
    end
  endtask

  task automatic test_redirect_stall();
    redirect = 1'b1; stall = 1'b1; redirectTarget = 32'h80;
    tick();
    exp_dec = {1'b1, 32'h1000_0010, 32'h40, 32'h44, 1'b0};
    tests++;
    if (programCounter !== 32'h44 || dec !== exp_dec) begin
      fails++; $display("FAIL redir_stall_hold: got pc %h dec %h expected pc %h dec %h",
                        programCounter, dec, 32'h44, exp_dec);
    end
    stall = 1'b0;
    tick();
    redirect = 1'b0;
    tests++;
    if (programCounter !== 32'h80) begin
      fails++; $display("FAIL redir_stall_release: got %h expected %h", programCounter, 32'h80);
    end
    tick();
    exp_dec = {1'b1, 32'h1000_0020, 32'h80, 32'h84, 1'b0};
    tests++;
    if (programCounter !== 32'h84 || dec !== exp_dec) begin
      fails++; $display("FAIL redir_stall_target: got pc %h dec %h expected pc %h dec %h",
                        programCounter, dec, 32'h84, exp_dec);
    end
  endtask

  task automatic test_flush();
    flush = 1'b1; stall = 1'b1; redirect = 1'b1; redirectTarget = 32'h300;
    tick();
    flush = 1'b0; stall = 1'b0; redirect = 1'b0;
    exp_dec = '0;
    tests++;
    if (programCounter !== 32'h180 || dec !== exp_dec) begin
      fails++; $display("FAIL flush_edge: got pc %h dec %h expected pc %h dec %h",
                        programCounter, dec, 32'h180, exp_dec);
    end
    tick();
    exp_dec = {1'b1, 32'h1000_0060, 32'h180, 32'h184, 1'b0};
    tests++;
    if (programCounter !== 32'h184 || dec !== exp_dec) begin
      fails++; $display("FAIL flush_target: got pc %h dec %h expected pc %h dec %h",
                        programCounter, dec, 32'h184, exp_dec);
    end
  endtask

  task automatic test_misaligned();
    redirect = 1'b1; redirectTarget = 32'h22;
    tick();
    redirect = 1'b0;
    tests++;
    if (programCounter !== 32'h22) begin
      fails++; $display("FAIL misalign_pc: got %h expected %h", programCounter, 32'h22);
    end
    tick();
    exp_dec = {1'b1, 32'h1000_0008, 32'h22, 32'h26, 1'b1};
    tests++;
    if (programCounter !== 32'h26 || dec !== exp_dec) begin
      fails++; $display("FAIL misalign_first: got pc %h dec %h expected pc %h dec %h",
                        programCounter, dec, 32'h26, exp_dec);
    end
    tick();
    exp_dec = {1'b1, 32'h1000_0009, 32'h26, 32'h2A, 1'b1};
    tests++;
    if (programCounter !== 32'h2A || dec !== exp_dec) begin
      fails++; $display("FAIL misalign_second: got pc %h dec %h expected pc %h dec %h",
                        programCounter, dec, 32'h2A, exp_dec);
    end
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirectTarget = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    tick();
    exp_dec = {1'b1, 32'h4FFF_FFFF, 32'hFFFF_FFFC, 32'h0, 1'b0};
    tests++;
    if (programCounter !== 32'h0 || dec !== exp_dec) begin
      fails++; $display("FAIL wrap: got pc %h dec %h expected pc %h dec %h",
                        programCounter, dec, 32'h0, exp_dec);
    end
    tick();
    exp_dec = {1'b1, 32'h1000_0000, 32'h0, 32'h4, 1'b0};
    tests++;
    if (programCounter !== 32'h4 || dec !== exp_dec) begin
      fails++; $display("FAIL wrap_after: got pc %h dec %h expected pc %h dec %h",
                        programCounter, dec, 32'h4, exp_dec);
    end
  endtask

  task automatic test_async_reset();
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    exp_dec = '0;
    tests++;
    if (programCounter !== 32'h0 || dec !== exp_dec) begin
      fails++; $display("FAIL async_reset: got pc %h dec %h expected pc %h dec %h",
                        programCounter, dec, 32'h0, exp_dec);
    end
    tick();
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_flush();
    test_misaligned();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
